// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow flag is enabled with the SERIAL_SUB_OVF_EN macro.
package serial_sub_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default operand/result width
   localparam int SS_WIDTH = 4;

   // Bits needed for a counter that can hold the value 'width'
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_sub_full_sub_bit.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B (mod 2^WIDTH) and Borrow (A < B unsigned),
// LSB first, one bit per clock, behind a start/busy/done handshake.
// Optional: define SERIAL_SUB_OVF_EN to add the registered signed-overflow
// output Ovf.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SS_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   // Holds the first WIDTH-1 difference bits; the final bit joins on the
   // completing edge straight from the bit subtractor.
   logic [WIDTH-2:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_br;

   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_a_shift;
   logic [WIDTH-1:0] w_b_shift;
   logic [WIDTH-2:0] w_res_shift;

   full_sub_bit u_bit (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_br),
      .d    (w_d),
      .bout (w_bout)
   );

   assign w_a_shift = {1'b0, r_a[WIDTH-1:1]};
   assign w_b_shift = {1'b0, r_b[WIDTH-1:1]};

   generate
      if (WIDTH > 2) begin : g_res_wide
         assign w_res_shift = {w_d, r_res[WIDTH-2:1]};
      end else begin : g_res_narrow
         assign w_res_shift = w_d;
      end
   endgenerate

`ifdef SERIAL_SUB_OVF_EN
   // On the last RUN cycle the operand LSBs are the original sign bits and
   // w_d is the result sign bit.
   logic w_ovf;
   assign w_ovf = (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
`endif

   // Controller, datapath shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         D       <= '0;
         Borrow  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         Ovf     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_br    <= 1'b0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a   <= w_a_shift;
               r_b   <= w_b_shift;
               r_res <= w_res_shift;
               r_br  <= w_bout;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  D       <= {w_d, r_res};
                  Borrow  <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                  Ovf     <= w_ovf;
`endif
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial, multicycle subtractor; the inverse operation of the team's 4-bit combinational adder (A, B in; sum O, Carry out).
- Computes D = A - B and Borrow, LSB first, one bit per clock, behind a start/busy/done handshake.
- Used as a compact arithmetic unit in the class datapath exercises, and as the sequential counterpart the adder benches check against (A + B, then subtract B to recover A).

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- A  input  WIDTH  minuend; sampled on the accept edge only.
- B  input  WIDTH  subtrahend; sampled on the accept edge only.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- D  output  WIDTH  difference A - B modulo 2^WIDTH; registered.
- Borrow  output  1  1 iff A < B, unsigned; registered.
- Ovf  output  1  only with SERIAL_SUB_OVF_EN (see Optional Feature).

Behaviour:
- Single clock domain. rst is synchronous and active-high; it has priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, D=0, Borrow=0, Ovf=0, internal shift registers=0, bit counter=0, borrow flop=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a clk edge with start=1:
  - A and B are captured into shift registers.
  - Internal borrow br=0; counter=0.
- RUN, each cycle, with a0/b0 = current LSBs of the shift registers:
  - d = a0^b0^br.
  - br_next = (~a0&b0) | (~(a0^b0)&br).
  - d is shifted into the result shift register from the MSB side; both operand registers shift right.
  - counter increments.
- RUN -> DONE after exactly WIDTH RUN cycles.
  - On that edge D <= result shift register (with the final bit included) and Borrow <= final br.
- DONE -> IDLE unconditionally after one cycle. done=1 only while in DONE.
- Latency: start sampled at edge 0, busy=1 for cycles 1..WIDTH, done=1 in cycle WIDTH+1. A new start is accepted no earlier than edge WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- D and Borrow change only on the RUN->DONE edge and hold afterwards until the next completion or a reset. Partial results are never visible.
- start in RUN or DONE is ignored, not queued.
- Changes on A/B after the accept edge have no effect.
- Reset mid-RUN aborts the operation: all outputs return to their reset values the next cycle and no done pulse is issued.
- Boundary cases:
  - A=B gives D=0, Borrow=0.
  - A=0, B=2^WIDTH-1 gives D=1, Borrow=1.
  - start held high continuously starts a new operation every WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port Ovf exists and is registered alongside D and Borrow.
  - Ovf=1 iff the signed (two's-complement) subtraction overflows: sign(A) != sign(B) and sign(D) != sign(A).
  - Ovf holds and resets exactly like Borrow.
- Undefined: no Ovf port and no related logic. All other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE, RUN, DONE).
  - default width constant SS_WIDTH=4.
  - counter width function clog2(WIDTH+1).
- One natural sub-module, full_sub_bit: combinational, inputs a, b, bin; outputs d, bout. Instantiated once and fed from the shift-register LSBs and the br flop.
- The FSM, counter and shift registers stay in serial_sub.

Test Plan:
- Reset, then start with A=4'b1111, B=4'b1111 -> busy for 4 cycles, done pulse in cycle 5, D=4'b0000, Borrow=0.
- A=4'd3, B=4'd5 -> D=4'b1110, Borrow=1. With SERIAL_SUB_OVF_EN: Ovf=0.
- A=4'b1000, B=4'b0001 -> D=4'b0111, Borrow=0. With SERIAL_SUB_OVF_EN: Ovf=1.
- Pulse start again on cycle 2 of RUN with different operands (A=0, B=1) -> ignored: first result is unchanged and there is exactly one done pulse.
- Start with A=9, B=2, assert rst in RUN cycle 2 -> next cycle busy=0, D=0, Borrow=0, and no done pulse within 10 cycles.
- Hold start=1 for 20 cycles with A=0, B=15 -> a done pulse every 6 cycles, each with D=4'b0001, Borrow=1.
